fp_sum_unpack_norm: RTL

//  Converts the signed two's-complement mantissa sum from the FP adder path back

---
 rtl/fp_alu_pkg.sv | 14 +
 rtl/fp_sum_unpack_norm_if.sv | 37 +++
 rtl/fp_sum_unpack_norm_negate.sv | 11 +
 rtl/fp_sum_unpack_norm.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/fp_alu_pkg.sv
// Shared FP adder-path constants and the unpack/normalise FSM state encoding.
package fp_alu_pkg;

  localparam int unsigned MANT_W  = 24;
  localparam int unsigned EXP_W   = 8;
  localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : fp_alu_pkg

// File: rtl/fp_sum_unpack_norm_if.sv
// Valid/ready bus between the mantissa adder, the unpack/normalise stage and the packer.
interface fp_sum_unpack_norm_if #(
  parameter int unsigned MANT_W = fp_alu_pkg::MANT_W,
  parameter int unsigned EXP_W  = fp_alu_pkg::EXP_W
);

  // Upstream side: signed mantissa sum and aligned exponent.
  logic                in_valid;
  logic                in_ready;
  logic [MANT_W+1:0]   in_sum;
  logic [EXP_W-1:0]    in_exp;

  // Downstream side: sign-magnitude normalised result and status flags.
  logic                out_valid;
  logic                out_ready;
  logic                out_sign;
  logic [MANT_W-1:0]   out_mant;
  logic [EXP_W-1:0]    out_exp;
  logic                out_zero;
  logic                out_uflow;
  logic                out_oflow;

  // Producer of sums and consumer of results (adder/packer, or a bench).
  modport master (
    output in_valid, in_sum, in_exp, out_ready,
    input  in_ready, out_valid, out_sign, out_mant, out_exp,
           out_zero, out_uflow, out_oflow
  );

  // The unpack/normalise block itself.
  modport slave (
    input  in_valid, in_sum, in_exp, out_ready,
    output in_ready, out_valid, out_sign, out_mant, out_exp,
           out_zero, out_uflow, out_oflow
  );

endinterface : fp_sum_unpack_norm_if

// File: rtl/fp_sum_unpack_norm_negate.sv
// Combinational two's-complement negation (~x + 1) of a W-bit vector.
module twos_negate_w #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] x_i,
  output logic [W-1:0] y_o
);

  assign y_o = ~x_i + W'(1);

endmodule : twos_negate_w

// File: rtl/fp_sum_unpack_norm.sv
// Converts a signed mantissa sum to sign-magnitude and normalises it,
// one shift per cycle, adjusting the exponent and flagging zero/uflow/oflow.
module fp_sum_unpack_norm #(
  parameter int unsigned MANT_W = fp_alu_pkg::MANT_W,
  parameter int unsigned EXP_W  = fp_alu_pkg::EXP_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fp_sum_unpack_norm_if.slave  bus
);

  import fp_alu_pkg::*;

  localparam int unsigned      SUM_W   = MANT_W + 2;
  localparam logic [EXP_W-1:0] EXP_TOP = '1;

  state_t              state_q, state_d;
  logic                sign_q, sign_d;
  logic [SUM_W-1:0]    mag_q, mag_d;
  logic [EXP_W-1:0]    exp_q, exp_d;

  logic                o_valid_q, o_valid_d;
  logic                o_sign_q, o_sign_d;
  logic [MANT_W-1:0]   o_mant_q, o_mant_d;
  logic [EXP_W-1:0]    o_exp_q, o_exp_d;
  logic                o_zero_q, o_zero_d;
  logic                o_uflow_q, o_uflow_d;
  logic                o_oflow_q, o_oflow_d;

  logic [SUM_W-1:0]    neg_sum;
  logic [EXP_W-1:0]    exp_inc;

  twos_negate_w #(
    .W (SUM_W)
  ) u_negate (
    .x_i (bus.in_sum),
    .y_o (neg_sum)
  );

  // Next-state, datapath and result-register logic for IDLE/NORM/DONE.
  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    mag_d     = mag_q;
    exp_d     = exp_q;
    o_valid_d = o_valid_q;
    o_sign_d  = o_sign_q;
    o_mant_d  = o_mant_q;
    o_exp_d   = o_exp_q;
    o_zero_d  = o_zero_q;
    o_uflow_d = o_uflow_q;
    o_oflow_d = o_oflow_q;
    // Saturating increment so an input exponent already at the top cannot wrap.
    exp_inc   = (exp_q == EXP_TOP) ? EXP_TOP : exp_q + EXP_W'(1);

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sign_d  = bus.in_sum[SUM_W-1];
          mag_d   = bus.in_sum[SUM_W-1] ? neg_sum : bus.in_sum;
          exp_d   = bus.in_exp;
          state_d = NORM;
        end
      end

      NORM: begin
        if (mag_q == '0) begin
          o_sign_d  = 1'b0;
          o_mant_d  = '0;
          o_exp_d   = '0;
          o_zero_d  = 1'b1;
          o_uflow_d = 1'b0;
          o_oflow_d = 1'b0;
          o_valid_d = 1'b1;
          state_d   = DONE;
        end else if (mag_q[SUM_W-1:MANT_W] != '0) begin
          mag_d = mag_q >> 1;
          exp_d = exp_inc;
          if (exp_inc == EXP_TOP) begin
            o_sign_d  = sign_q;
            o_mant_d  = '0;
            o_exp_d   = EXP_TOP;
            o_zero_d  = 1'b0;
            o_uflow_d = 1'b0;
            o_oflow_d = 1'b1;
            o_valid_d = 1'b1;
            state_d   = DONE;
          end
        end else if (mag_q[MANT_W-1]) begin
          o_sign_d  = sign_q;
          o_mant_d  = mag_q[MANT_W-1:0];
          o_exp_d   = exp_q;
          o_zero_d  = 1'b0;
          o_uflow_d = 1'b0;
          o_oflow_d = 1'b0;
          o_valid_d = 1'b1;
          state_d   = DONE;
        end else if (exp_q <= EXP_W'(1)) begin
          o_sign_d  = sign_q;
          o_mant_d  = mag_q[MANT_W-1:0];
          o_exp_d   = '0;
          o_zero_d  = 1'b0;
          o_uflow_d = 1'b1;
          o_oflow_d = 1'b0;
          o_valid_d = 1'b1;
          state_d   = DONE;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - EXP_W'(1);
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          o_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end

      default: begin
        o_valid_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // State, working registers and registered outputs; reset drops any pending item.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      exp_q     <= '0;
      o_valid_q <= 1'b0;
      o_sign_q  <= 1'b0;
      o_mant_q  <= '0;
      o_exp_q   <= '0;
      o_zero_q  <= 1'b0;
      o_uflow_q <= 1'b0;
      o_oflow_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      mag_q     <= mag_d;
      exp_q     <= exp_d;
      o_valid_q <= o_valid_d;
      o_sign_q  <= o_sign_d;
      o_mant_q  <= o_mant_d;
      o_exp_q   <= o_exp_d;
      o_zero_q  <= o_zero_d;
      o_uflow_q <= o_uflow_d;
      o_oflow_q <= o_oflow_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = o_valid_q;
  assign bus.out_sign  = o_sign_q;
  assign bus.out_mant  = o_mant_q;
  assign bus.out_exp   = o_exp_q;
  assign bus.out_zero  = o_zero_q;
  assign bus.out_uflow = o_uflow_q;
  assign bus.out_oflow = o_oflow_q;

endmodule : fp_sum_unpack_norm
